// File: rtl/i2c_eeprom_master.sv
// i2c_eeprom_master: I2C initiator for single-byte random write / random read
// on a 16-bit-addressed EEPROM. The lines are open-drain: *_padoen_o=0 pulls
// the line low and *_padoen_o=1 releases it.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        command handshake (ready only while idle)
//   req_we_i, req_addr_i, req_wdata_i  command: 1=write, EEPROM address, data
//   rsp_valid_o                    one-cycle completion pulse
//   rsp_rdata_o, rsp_err_o         read data / NACK flag, held until next rsp
//   busy_o                         transaction in progress
//   scl_pad_i/o, scl_padoen_o      SCL pad (o is constant 0)
//   sda_pad_i/o, sda_padoen_o      SDA pad (o is constant 0)
//
// Each bus slot is four quarters (q0..q3) of CLK_DIV cycles. The pad enables
// are registered from the current slot/quarter, so the pads trail the
// internal quarter counter by one clock; every edge shifts by the same amount.
module i2c_eeprom_master #(
    parameter int unsigned CLK_DIV  = 16,
    parameter logic [6:0]  DEV_ADDR = 7'b010_1010
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    input  logic        scl_pad_i,
    output logic        scl_pad_o,
    output logic        scl_padoen_o,
    input  logic        sda_pad_i,
    output logic        sda_pad_o,
    output logic        sda_padoen_o
);
    localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_TX, ST_ACK, ST_RSTART,
        ST_RX, ST_MNACK, ST_STOP, ST_RSP
    } state_e;

    state_e          state_q;
    logic [QW-1:0]   qcnt_q;
    logic [1:0]      phase_q;
    logic [2:0]      bit_q;
    logic [1:0]      byte_q;
    logic [7:0]      sh_q;
    logic            we_q;
    logic [15:0]     addr_q;
    logic [7:0]      wdata_q;
    logic            nack_q;
    logic            err_q;
    logic            scl_oen_q, sda_oen_q;
    logic            rsp_valid_q, rsp_err_q, busy_q;
    logic [7:0]      rsp_rdata_q;

    logic q_last, stretch, scl_rel, sda_rel;

    assign q_last  = (qcnt_q == QW'(CLK_DIV - 1));
    // A responder holding SCL low after we released it freezes the quarter.
    assign stretch = (phase_q inside {2'd1, 2'd2}) && scl_oen_q && !scl_pad_i;

    // Line levels wanted for the current slot and quarter (1 = release).
    always_comb begin
        scl_rel = 1'b1;
        sda_rel = 1'b1;
        case (state_q)
            ST_START: begin
                scl_rel = (phase_q != 2'd3);
                sda_rel = (phase_q < 2'd2);
            end
            ST_RSTART: begin
                scl_rel = phase_q inside {2'd1, 2'd2};
                sda_rel = (phase_q < 2'd2);
            end
            ST_STOP: begin
                scl_rel = (phase_q != 2'd0);
                sda_rel = (phase_q >= 2'd2);
            end
            ST_TX: begin
                scl_rel = phase_q inside {2'd1, 2'd2};
                sda_rel = sh_q[7];
            end
            ST_ACK, ST_RX, ST_MNACK: scl_rel = phase_q inside {2'd1, 2'd2};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            qcnt_q      <= '0;
            phase_q     <= 2'd0;
            bit_q       <= 3'd0;
            byte_q      <= 2'd0;
            sh_q        <= 8'h00;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            nack_q      <= 1'b0;
            err_q       <= 1'b0;
            scl_oen_q   <= 1'b1;
            sda_oen_q   <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            scl_oen_q   <= scl_rel;
            sda_oen_q   <= sda_rel;
            case (state_q)
                ST_IDLE: if (req_valid_i) begin
                    we_q    <= req_we_i;
                    addr_q  <= req_addr_i;
                    wdata_q <= req_wdata_i;
                    busy_q  <= 1'b1;
                    err_q   <= 1'b0;
                    qcnt_q  <= '0;
                    phase_q <= 2'd0;
                    state_q <= ST_START;
                end
                ST_RSP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: if (!stretch) begin
                    if (!q_last) begin
                        qcnt_q <= qcnt_q + 1'b1;
                    end else begin
                        qcnt_q  <= '0;
                        phase_q <= phase_q + 2'd1;
                        // Sample SDA at the end of the SCL-high window.
                        if (phase_q == 2'd2) begin
                            if (state_q == ST_ACK) nack_q <= sda_pad_i;
                            if (state_q == ST_RX)  sh_q   <= {sh_q[6:0], sda_pad_i};
                        end
                        if (phase_q == 2'd3) begin
                            case (state_q)
                                ST_START: begin
                                    sh_q    <= {DEV_ADDR, 1'b0};
                                    bit_q   <= 3'd7;
                                    byte_q  <= 2'd0;
                                    state_q <= ST_TX;
                                end
                                ST_TX: begin
                                    if (bit_q == 3'd0) begin
                                        state_q <= ST_ACK;
                                    end else begin
                                        bit_q <= bit_q - 3'd1;
                                        sh_q  <= {sh_q[6:0], 1'b0};
                                    end
                                end
                                ST_ACK: begin
                                    if (nack_q) begin
                                        err_q   <= 1'b1;
                                        state_q <= ST_STOP;
                                    end else begin
                                        byte_q <= byte_q + 2'd1;
                                        bit_q  <= 3'd7;
                                        case (byte_q)
                                            2'd0: begin sh_q <= addr_q[15:8]; state_q <= ST_TX; end
                                            2'd1: begin sh_q <= addr_q[7:0];  state_q <= ST_TX; end
                                            2'd2: begin
                                                if (we_q) begin
                                                    sh_q    <= wdata_q;
                                                    state_q <= ST_TX;
                                                end else begin
                                                    state_q <= ST_RSTART;
                                                end
                                            end
                                            default: state_q <= we_q ? ST_STOP : ST_RX;
                                        endcase
                                    end
                                end
                                ST_RSTART: begin
                                    sh_q    <= {DEV_ADDR, 1'b1};
                                    state_q <= ST_TX;
                                end
                                ST_RX: begin
                                    if (bit_q == 3'd0) state_q <= ST_MNACK;
                                    else               bit_q   <= bit_q - 3'd1;
                                end
                                ST_MNACK: state_q <= ST_STOP;
                                ST_STOP: begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= err_q;
                                    rsp_rdata_q <= (err_q || we_q) ? 8'h00 : sh_q;
                                    state_q     <= ST_RSP;
                                end
                                default: state_q <= ST_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = busy_q;
    assign scl_pad_o    = 1'b0;
    assign sda_pad_o    = 1'b0;
    assign scl_padoen_o = scl_oen_q;
    assign sda_padoen_o = sda_oen_q;
endmodule

// File: tb/tb_i2c_eeprom_master.sv
// Bench for i2c_eeprom_master: behavioural EEPROM responder on the open-drain
// wires, reference memory and latency formula, directed + random commands.
module tb_i2c_eeprom_master;
    localparam int         CD  = 4;
    localparam logic [6:0] DEV = 7'b010_1010;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [7:0]  req_wdata = 8'h0;
    logic        req_ready_o, rsp_valid_o, rsp_err_o, busy_o;
    logic [7:0]  rsp_rdata_o;
    logic        scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
    logic        tb_scl_low = 1'b0, s_sda_low = 1'b0;
    wire         scl_w = scl_padoen_o & ~tb_scl_low;
    wire         sda_w = sda_padoen_o & ~s_sda_low;

    i2c_eeprom_master #(.CLK_DIV(CD), .DEV_ADDR(DEV)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o),
        .scl_pad_i(scl_w), .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
        .sda_pad_i(sda_w), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_rdy_busy = 0;
    always @(negedge clk) if (busy_o && req_ready_o) n_rdy_busy <= n_rdy_busy + 1;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    endtask

    // ---------------- responder model ----------------
    localparam int S_IDLE = 0, S_RX = 1, S_ACK = 2, S_TX = 3, S_MACK = 4;
    logic [6:0]  resp_dev = DEV;
    logic        stretch_arm = 1'b0;
    event        ev_st;
    logic [7:0]  smem [bit [15:0]];
    int          s_ph = S_IDLE, s_bits = 0, s_byte_n = 0, n_rstart = 0, n_stop = 0;
    logic [7:0]  s_sh = 8'h0;
    logic [15:0] s_ptr = 16'h0;
    logic        s_rd = 1'b0, s_mnack = 1'b0, p_scl = 1'b1, p_sda = 1'b1, s_ack;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] smem_rd(input logic [15:0] a);
        return smem.exists(a) ? smem[a] : init_val(a);
    endfunction

    always @(scl_w or sda_w) begin
        if (scl_w !== p_scl) begin
            if (scl_w) begin
                case (s_ph)
                    S_RX:   begin s_sh = {s_sh[6:0], sda_w}; s_bits++; end
                    S_TX:   s_bits++;
                    S_MACK: begin s_mnack = sda_w; s_ph = S_IDLE; end
                    default: ;
                endcase
            end else begin
                case (s_ph)
                    S_RX: begin
                        if (s_bits == 8) begin
                            s_ack = 1'b1;
                            if (s_byte_n == 0) begin
                                s_ack = (s_sh[7:1] == resp_dev);
                                s_rd  = s_sh[0];
                            end else if (!s_rd) begin
                                if (s_byte_n == 1)      s_ptr[15:8] = s_sh;
                                else if (s_byte_n == 2) s_ptr[7:0]  = s_sh;
                                else begin smem[s_ptr] = s_sh; s_ptr++; end
                            end
                            if (s_ack) begin s_sda_low = 1'b1; s_ph = S_ACK; end
                            else s_ph = S_IDLE;
                        end else if (stretch_arm && s_byte_n == 1 && s_bits == 4) begin
                            -> ev_st;
                        end
                    end
                    S_ACK: begin
                        s_sda_low = 1'b0;
                        s_byte_n++;
                        s_bits = 0;
                        if (s_rd && s_byte_n == 1) begin
                            s_sh = smem_rd(s_ptr);
                            s_ptr++;
                            s_sda_low = ~s_sh[7];
                            s_ph = S_TX;
                        end else begin
                            s_ph = S_RX;
                        end
                    end
                    S_TX: begin
                        if (s_bits == 8) begin s_sda_low = 1'b0; s_ph = S_MACK; end
                        else s_sda_low = ~s_sh[7 - s_bits];
                    end
                    default: ;
                endcase
            end
        end else if (scl_w && (sda_w !== p_sda)) begin
            if (!sda_w) begin
                if (s_ph != S_IDLE) n_rstart++;
                s_ph = S_RX; s_bits = 0; s_byte_n = 0; s_sda_low = 1'b0;
            end else begin
                n_stop++;
                s_ph = S_IDLE; s_sda_low = 1'b0;
            end
        end
        p_scl = scl_w;
        p_sda = sda_w;
    end

    // Clock stretch: hold SCL low for 100 clocks once the master releases it.
    initial forever begin
        @(ev_st);
        tb_scl_low = 1'b1;
        @(posedge scl_padoen_o);
        repeat (100) @(posedge clk);
        #1 tb_scl_low = 1'b0;
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [bit [15:0]];

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Slots per transaction: START+4x(8+ACK)+STOP, or read with RSTART/RX/NACK,
    // or START + address byte + ACK + STOP when the address is refused.
    function automatic int exp_lat(input logic we, input logic nack);
        return 1 + 4 * CD * (nack ? 11 : (we ? 38 : 48));
    endfunction

    task automatic run_txn(input logic we, input logic [15:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output logic er, output int lat);
        int n, acc;
        logic tmo;
        tmo = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready_o && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) tmo = 1'b1;
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy", busy_o, 1);
        n = 0;
        while (!rsp_valid_o && n < 10000) begin @(negedge clk); n++; end
        if (n >= 10000) tmo = 1'b1;
        chk("tmo", tmo, 0);
        lat = cyc - acc;
        rd  = rsp_rdata_o;
        er  = rsp_err_o;
    endtask

    task automatic txn_chk(input logic we, input logic [15:0] a, input logic [7:0] d,
                           input logic nack);
        logic [7:0] rd;
        logic er;
        int lat;
        resp_dev = nack ? (DEV ^ 7'h01) : DEV;
        run_txn(we, a, d, rd, er, lat);
        resp_dev = DEV;
        chk("err", er, nack);
        chk("lat", lat, exp_lat(we, nack));
        if (nack) chk("rdata_nack", rd, 0);
        else if (!we) chk("rdata", rd, ref_rd(a));
        else begin
            ref_mem[a] = d;
            chk("mem", smem_rd(a), d);
        end
    endtask

    initial begin
        logic [7:0] rd, d1, d2;
        logic er;
        int lat, r0, n, acc1, acc2, rsp1, rsp2;
        logic [15:0] a;
        logic [7:0] d;

        // reset state
        #23;
        chk("rst_scl_oen", scl_padoen_o, 1);
        chk("rst_sda_oen", sda_padoen_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        chk("rst_err", rsp_err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_pad_o", {scl_pad_o, sda_pad_o}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("ready_idle", req_ready_o, 1);

        // write 0xA5 to 0x1234
        txn_chk(1'b1, 16'h1234, 8'hA5, 1'b0);

        // read it back: repeated start and master NACK expected
        r0 = n_rstart;
        run_txn(1'b0, 16'h1234, 8'h00, rd, er, lat);
        chk("rd_data", rd, 8'hA5);
        chk("rd_err", er, 0);
        chk("rd_lat", lat, exp_lat(1'b0, 1'b0));
        chk("rd_rstart", n_rstart - r0, 1);
        chk("rd_mnack", s_mnack, 1);
        repeat (10) @(negedge clk);
        chk("rd_hold", rsp_rdata_o, 8'hA5);

        // responder at a different address: NACK, STOP, err
        r0 = n_stop;
        resp_dev = 7'h2B;
        run_txn(1'b1, 16'h0777, 8'h11, rd, er, lat);
        resp_dev = DEV;
        chk("nack_err", er, 1);
        chk("nack_rdata", rd, 0);
        chk("nack_lat", lat, exp_lat(1'b1, 1'b1));
        chk("nack_stop", n_stop - r0, 1);
        chk("nack_mem", smem_rd(16'h0777), ref_rd(16'h0777));

        // clock stretch of 100 cycles in the address-high byte
        a = 16'h4000 | 16'($urandom_range(0, 31));
        d = 8'($urandom);
        stretch_arm = 1'b1;
        run_txn(1'b1, a, d, rd, er, lat);
        stretch_arm = 1'b0;
        ref_mem[a] = d;
        chk("st_err", er, 0);
        chk("st_lat", lat, exp_lat(1'b1, 1'b0) + 100);
        chk("st_mem", smem_rd(a), d);
        txn_chk(1'b0, a, 8'h00, 1'b0);

        // reset in the middle of the address-low byte
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h5A5A; req_wdata = 8'h77;
        @(negedge clk); req_valid = 1'b0;
        n = 0;
        while (!(s_ph == S_RX && s_byte_n == 2 && s_bits == 3) && n < 5000) begin
            @(negedge clk); n++;
        end
        chk("abort_reach", n < 5000, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_scl_oen", scl_padoen_o, 1);
        chk("abort_sda_oen", sda_padoen_o, 1);
        chk("abort_busy", busy_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", req_ready_o, 1);
        txn_chk(1'b1, 16'h2468, 8'h3E, 1'b0);

        // back-to-back reads with valid held high
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234;
        n = 0;
        while (!req_ready_o && n < 100) begin @(negedge clk); n++; end
        acc1 = cyc;
        @(negedge clk);
        req_addr = 16'h2468;
        n = 0;
        while (!rsp_valid_o && n < 10000) begin @(negedge clk); n++; end
        rsp1 = cyc; d1 = rsp_rdata_o;
        @(negedge clk);
        n = 0;
        while (!req_ready_o && n < 10000) begin @(negedge clk); n++; end
        acc2 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 10000) begin @(negedge clk); n++; end
        rsp2 = cyc; d2 = rsp_rdata_o;
        chk("b2b_lat1", rsp1 - acc1, exp_lat(1'b0, 1'b0));
        chk("b2b_acc2", acc2, rsp1 + 1);
        chk("b2b_lat2", rsp2 - acc2, exp_lat(1'b0, 1'b0));
        chk("b2b_d1", d1, ref_rd(16'h1234));
        chk("b2b_d2", d2, ref_rd(16'h2468));
        chk("b2b_rdy_busy", n_rdy_busy, 0);

        // random mix of writes, reads and refused addresses
        for (int i = 0; i < 16; i++) begin
            txn_chk(1'($urandom_range(0, 1)), 16'h4000 | 16'($urandom_range(0, 31)),
                    8'($urandom), $urandom_range(0, 5) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/i2c_eeprom_master.md
Name: i2c_eeprom_master

Overview:
Synchronous I2C initiator that performs single-byte random write and random read transactions on a 16-bit-addressed I2C EEPROM. It is the initiator counterpart to the team's EEPROM responder model. It drives SCL/SDA open-drain through the i2c_buf-style pad signals, from a simple request/response command port. Used by the boot/config path and as the active driver in the EEPROM testbench.

Parameters:
CLK_DIV, 16, clk_i cycles per SCL quarter-period (minimum 2); SCL period = 4*CLK_DIV cycles
DEV_ADDR, 7'b010_1010, 7-bit I2C device address placed in every address byte

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset, asynchronous, active-low
req_valid_i  input  1  command request valid
req_ready_o  output  1  command accepted when valid&ready
req_we_i  input  1  1 = write, 0 = read
req_addr_i  input  16  EEPROM byte address
req_wdata_i  input  8  write data
rsp_valid_o  output  1  one-cycle response pulse
rsp_rdata_o  output  8  read data, valid with rsp_valid_o
rsp_err_o  output  1  NACK seen, valid with rsp_valid_o
busy_o  output  1  transaction in progress
scl_pad_i  input  1  SCL line level
scl_pad_o  output  1  SCL drive value, constant 0
scl_padoen_o  output  1  SCL output enable, active-low (0 = pull low)
sda_pad_i  input  1  SDA line level
sda_pad_o  output  1  SDA drive value, constant 0
sda_padoen_o  output  1  SDA output enable, active-low

Behaviour:
- Reset: state IDLE, both padoen=1 (lines released), rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0. Reset mid-transaction releases both lines immediately (async); no STOP is generated.
- req_ready_o = (state==IDLE). On valid&ready, latch we/addr/wdata and raise busy_o next cycle. Requests are ignored while busy.
- Timing: every bit slot is 4 quarters q0..q3 of CLK_DIV cycles each, counted by a quarter counter and a 2-bit phase.
  - Data bit: q0 SCL low, SDA set to bit (1 = release); q1,q2 SCL released; SDA sampled on last cycle of q2; q3 SCL low.
  - START: q0,q1 both released; q2 SDA low; q3 SCL low.
  - RSTART: q0 SCL low, SDA released; q1 SCL released; q2 SDA low; q3 SCL low.
  - STOP: q0 SCL low, SDA low; q1 SCL released; q2,q3 both released.
- Clock stretching: in q1/q2 of any slot, if SCL is released but scl_pad_i=0, the quarter counter holds. No timeout.
- FSM: IDLE -> START -> TX_BYTE(8 bits MSB first) -> ACK (master releases SDA, samples) -> next byte.
  - Write: {DEV_ADDR,0}, addr[15:8], addr[7:0], wdata, each with ACK, then STOP -> RSP.
  - Read: {DEV_ADDR,0}, addr[15:8], addr[7:0], RSTART, {DEV_ADDR,1}, RX_BYTE (8 bits, master releases SDA, shifts sampled bits in MSB first), master NACK (SDA released), STOP -> RSP.
  - Any ACK slot sampling SDA=1 -> skip remaining bytes -> STOP -> RSP with err=1, rdata=0.
  - RSP: rsp_valid_o=1 for exactly one cycle, no backpressure; then IDLE with busy_o=0 in the same cycle.
- Latency without stretching: rsp_valid_o is asserted 1 + 4*CLK_DIV*N cycles after the accept cycle. N = 38 slots for write, 48 for read, 11 for an address NACK (START + 9 + STOP).
- rsp_rdata_o/rsp_err_o hold their values until the next rsp_valid_o.
- Multi-master arbitration is not supported; SDA mismatch while transmitting is ignored.

Test Plan:
- Write 0xA5 to 0x1234 with responder at DEV_ADDR, CLK_DIV=4 -> all ACKs; rsp_valid_o exactly 1+608 cycles after accept; err=0; responder mem[0x1234]=0xA5.
- Read 0x1234 after previous write -> repeated START observed, rsp_rdata_o=0xA5, err=0, last bit NACKed by master, rsp after 1+768 cycles.
- Responder at 7'h2B, write request -> NACK on first byte, STOP follows, rsp err=1, rdata=0, rsp after 1+176 cycles.
- Bench holds SCL low 100 cycles during q1 of addr_hi bit 3 -> transaction extended by exactly 100 cycles, data correct, err=0.
- Assert rst_ni low mid-addr_lo byte -> scl_padoen_o=sda_padoen_o=1 the same cycle, busy_o=0, req_ready_o=1 after release; next write completes normally.
- req_valid_i held high for two back-to-back reads -> req_ready_o low while busy; second request accepted the cycle after first rsp_valid_o, both data correct.
